// File: rtl/id_inst_buffer_pkg.sv
// Shared constants and types for the decode-side instruction buffer.
// Fetch bus layout is {PC, Inst}.
package id_inst_buffer_pkg;

  localparam int IF_BUS_W = 64;
  localparam int PC_HI    = 63;
  localparam int PC_LO    = 32;
  localparam int INST_HI  = 31;
  localparam int INST_LO  = 0;

  localparam logic RstEn = 1'b1;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [31:0] RESET_PC = 32'h1C00_0000;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

  function automatic logic pc_misaligned(
    input logic [31:0] pc
  );
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/id_inst_buffer_if.sv
// Fetch-in and decode-out handshakes of the instruction buffer.
// slave = buffer side, master = fetch/decode environment.
interface id_inst_buffer_if;
  import id_inst_buffer_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [IF_BUS_W-1:0] in_bus;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         out_pc;
  logic [31:0]         out_inst;
  logic                out_adef;

  modport slave (
    input  in_valid, in_bus, out_ready,
    output in_ready, out_valid,
    output out_pc, out_inst, out_adef
  );

  modport master (
    output in_valid, in_bus, out_ready,
    input  in_ready, out_valid,
    input  out_pc, out_inst, out_adef
  );

endinterface

// File: rtl/id_inst_buffer.sv
// In-order FIFO between fetch and decode; flush drops everything.
// Head entry is a combinational read, so a push shows up one cycle later.
module id_inst_buffer
  import id_inst_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              excp_flush,
  id_inst_buffer_if.slave   bus,
  output logic [PTR_W:0]    count
);

  localparam int CW = PTR_W + 1;
  localparam logic [PTR_W:0] FULL_CNT = CW'(DEPTH);

  logic [IF_BUS_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W:0]      r_count;

  occ_e w_occ;
  logic w_flush;
  logic w_push;
  logic w_pop;
  logic [IF_BUS_W-1:0] w_head;

  always_comb begin
    w_occ = OCC_PARTIAL;
    unique case (1'b1)
      (r_count == '0):       w_occ = OCC_EMPTY;
      (r_count == FULL_CNT): w_occ = OCC_FULL;
      default:               w_occ = OCC_PARTIAL;
    endcase
  end

  // Ready comes from registered occupancy only: a full
  // buffer stays closed even if decode drains this cycle.
  assign bus.in_ready  = (w_occ != OCC_FULL);
  assign bus.out_valid = (w_occ != OCC_EMPTY);

  assign w_flush = flush | excp_flush;
  assign w_push  = bus.in_valid & bus.in_ready & ~w_flush;
  assign w_pop   = bus.out_valid & bus.out_ready & ~w_flush;

  assign w_head       = r_mem[r_rd_ptr];
  assign bus.out_pc   = w_head[PC_HI:PC_LO];
  assign bus.out_inst = w_head[INST_HI:INST_LO];
  assign bus.out_adef = pc_misaligned(w_head[PC_HI:PC_LO]);
  assign count        = r_count;

  always_ff @(posedge clk) begin
    if (reset == RstEn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset != RstEn && w_push)
      r_mem[r_wr_ptr] <= bus.in_bus;
  end

endmodule

// File: tb/tb_id_inst_buffer.sv
// Scoreboard bench for id_inst_buffer: stimulus queues expected packets,
// a negedge monitor pops and compares on every accepted head.
module tb_id_inst_buffer;
  import id_inst_buffer_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       excp_flush;
  logic [2:0] count;

  id_inst_buffer_if ifc ();

  id_inst_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .excp_flush (excp_flush),
    .bus        (ifc),
    .count      (count)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, req);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && flush === 1'b0 && excp_flush === 1'b0
        && ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_pop: got pc %h required none",
                 ifc.out_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_pc", ifc.out_pc, e.pc);
        chk("out_inst", ifc.out_inst, e.inst);
        chk("out_adef", {31'b0, ifc.out_adef}, {31'b0, e.adef});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one packet for one cycle; acc says whether it must be captured.
  task automatic offer(input logic [31:0] pc, input logic [31:0] inst,
                       input bit acc);
    exp_t e;
    ifc.in_valid = 1'b1;
    ifc.in_bus   = {pc, inst};
    if (acc) begin
      e.pc   = pc;
      e.inst = inst;
      e.adef = (pc[1:0] != 2'b00);
      q.push_back(e);
    end
    tick();
    ifc.in_valid = 1'b0;
  endtask

  task automatic chk_state(input string nm, input logic [2:0] c,
                           input logic v, input logic r);
    chk({nm, "_count"}, {29'b0, count}, {29'b0, c});
    chk({nm, "_valid"}, {31'b0, ifc.out_valid}, {31'b0, v});
    chk({nm, "_ready"}, {31'b0, ifc.in_ready}, {31'b0, r});
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    excp_flush = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_bus = '0;
    ifc.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk_state("reset", 3'd0, 1'b0, 1'b1);

    // single push, visible next cycle
    offer(RESET_PC, 32'h0280_0000, 1'b1);
    chk_state("single", 3'd1, 1'b1, 1'b1);
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    chk_state("single_drain", 3'd0, 1'b0, 1'b1);

    // fill to full, 5th not captured
    for (int i = 0; i < 4; i++)
      offer(RESET_PC + 32'(4 * i), 32'h0010_0000 + 32'(i), 1'b1);
    chk_state("full", 3'd4, 1'b1, 1'b0);
    offer(32'h1C00_0010, 32'hDEAD_0005, 1'b0);
    chk_state("full_hold", 3'd4, 1'b1, 1'b0);
    // pop while full with in_valid: push must not slip in
    ifc.out_ready = 1'b1;
    offer(32'h1C00_0014, 32'hDEAD_0006, 1'b0);
    chk_state("full_pop", 3'd3, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    ifc.out_ready = 1'b0;
    chk_state("full_drain", 3'd0, 1'b0, 1'b1);

    // streaming, pointers wrap
    ifc.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(32'h1C00_0200 + 32'(4 * i), 32'h0300_0000 + 32'(i), 1'b1);
      chk({"stream_count"}, {29'b0, count}, 32'd1);
    end
    tick();
    ifc.out_ready = 1'b0;
    chk_state("stream_end", 3'd0, 1'b0, 1'b1);

    // flush with push and pop attempted
    for (int i = 0; i < 3; i++)
      offer(32'h1C00_0300 + 32'(4 * i), 32'h0400_0000 + 32'(i), 1'b1);
    chk_state("pre_flush", 3'd3, 1'b1, 1'b1);
    flush = 1'b1;
    ifc.out_ready = 1'b1;
    offer(32'h1C00_0400, 32'hBAD0_0001, 1'b0);
    flush = 1'b0;
    ifc.out_ready = 1'b0;
    q.delete();
    chk_state("flush", 3'd0, 1'b0, 1'b1);
    offer(32'h1C00_0100, 32'h0500_0000, 1'b1);
    chk_state("post_flush", 3'd1, 1'b1, 1'b1);
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;

    // exception flush alone
    offer(32'h1C00_0500, 32'h0600_0000, 1'b1);
    offer(32'h1C00_0504, 32'h0600_0001, 1'b1);
    chk_state("pre_excp", 3'd2, 1'b1, 1'b1);
    excp_flush = 1'b1;
    tick();
    excp_flush = 1'b0;
    q.delete();
    chk_state("excp", 3'd0, 1'b0, 1'b1);

    // reset mid-stream
    offer(32'h1C00_0600, 32'h0700_0000, 1'b1);
    offer(32'h1C00_0604, 32'h0700_0001, 1'b1);
    chk_state("pre_rst", 3'd2, 1'b1, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    chk_state("mid_rst", 3'd0, 1'b0, 1'b1);

    // misaligned PC flag
    offer(32'h1C00_0002, 32'h0800_0000, 1'b1);
    chk({"adef_head"}, {31'b0, ifc.out_adef}, 32'd1);
    offer(32'h1C00_0004, 32'h0800_0001, 1'b1);
    ifc.out_ready = 1'b1;
    tick();
    tick();
    ifc.out_ready = 1'b0;
    chk_state("adef_end", 3'd0, 1'b0, 1'b1);

    tick();
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
